// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg
// Shared types and constants for the tick scheduler: FSM state encoding,
// configuration command/mode encodings, the per-channel control flags and
// a helper that sizes the channel index.
// No ports (package).

package tick_sched_pkg;

   // Sweep controller states
   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StSweep = 1'b1
   } sched_state_e;

   // cfg_start encodings
   localparam logic CFG_STOP  = 1'b0;
   localparam logic CFG_START = 1'b1;

   // cfg_periodic encodings
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Width-independent part of a channel record; the count/period fields are
   // sized by the scheduler's CNT_W and wrapped around this in the top.
   typedef struct packed {
      logic active;
      logic periodic;
   } ch_ctrl_t;

   // Channel index width, never less than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Free-running 0..DIV_VAL counter that produces the base tick.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   wrap  out  combinational: counter is at DIV_VAL this cycle
//   tick  out  registered one-cycle pulse, high the cycle after wrap

module tick_prescaler #(
   parameter int unsigned DIV_VAL = 9999
) (
   input  logic clk,
   input  logic rst_n,
   output logic wrap,
   output logic tick
);

   localparam int unsigned PW = (DIV_VAL > 0) ? $clog2(DIV_VAL + 1) : 1;

   logic [PW-1:0] cnt_q, cnt_d;
   logic          tick_q;

   always_comb begin
      wrap  = (cnt_q == PW'(DIV_VAL));
      cnt_d = wrap ? '0 : cnt_q + PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= wrap;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler
// Shared timebase: divides clk into a base tick and, once per tick, sweeps
// NUM_CH timer channels through a single decrement datapath. Each channel
// emits a one-cycle fire pulse on expiry, usable as a clock enable.
// Ports:
//   clk           in   system clock, all logic on rising edge
//   rst_n         in   asynchronous active-low reset
//   cfg_valid     in   configuration request
//   cfg_ready     out  high while idle; request taken on valid && ready
//   cfg_ch        in   target channel (out-of-range ids are accepted, ignored)
//   cfg_start     in   CFG_START = start/restart, CFG_STOP = stop
//   cfg_periodic  in   MODE_PERIODIC = auto-reload, MODE_ONESHOT = one-shot
//   cfg_period    in   period in base ticks (0 on start acts as stop)
//   tick          out  one-cycle base tick pulse
//   ch_fire       out  one-cycle expiry pulse per channel
//   ch_busy       out  channel active flags

module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int unsigned DIV_VAL = 9999,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [idx_width(NUM_CH)-1:0]  cfg_ch,
   input  logic                          cfg_start,
   input  logic                          cfg_periodic,
   input  logic [CNT_W-1:0]              cfg_period,
   output logic                          tick,
   output logic [NUM_CH-1:0]             ch_fire,
   output logic [NUM_CH-1:0]             ch_busy
);

   localparam int unsigned CH_W = idx_width(NUM_CH);

   typedef struct packed {
      ch_ctrl_t         ctrl;
      logic [CNT_W-1:0] count;
      logic [CNT_W-1:0] period;
   } ch_rec_t;

   sched_state_e     state_q, state_d;
   logic [CH_W-1:0]  idx_q, idx_d;
   ch_rec_t          ch_q [NUM_CH];
   ch_rec_t          ch_d [NUM_CH];
   logic [NUM_CH-1:0] fire_q, fire_d;
   logic             presc_wrap;
   logic             cfg_hit;

   tick_prescaler #(
      .DIV_VAL(DIV_VAL)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .wrap (presc_wrap),
      .tick (tick)
   );

   // Sweep controller: idle until the prescaler wraps, then one channel per
   // cycle. Entering SWEEP on the wrap edge lines idx=0 up with tick=1.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (presc_wrap) begin
               state_d = StSweep;
               idx_d   = '0;
            end
         end
         StSweep: begin
            if (idx_q == CH_W'(NUM_CH - 1)) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CH_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   // Config is only taken while idle, so it never collides with the sweep
   // write port; a request in the wrap cycle lands before the sweep reads.
   assign cfg_ready = (state_q == StIdle);
   assign cfg_hit   = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);

   always_comb begin
      ch_d   = ch_q;
      fire_d = '0;

      if (cfg_hit) begin
         if ((cfg_start == CFG_START) && (cfg_period != '0)) begin
            ch_d[cfg_ch].ctrl.active   = 1'b1;
            ch_d[cfg_ch].ctrl.periodic = cfg_periodic;
            ch_d[cfg_ch].count         = cfg_period;
            ch_d[cfg_ch].period        = cfg_period;
         end else begin
            // Explicit stop, or start with a zero period
            ch_d[cfg_ch].ctrl.active = 1'b0;
         end
      end

      if ((state_q == StSweep) && ch_q[idx_q].ctrl.active) begin
         if (ch_q[idx_q].count > CNT_W'(1)) begin
            ch_d[idx_q].count = ch_q[idx_q].count - CNT_W'(1);
         end else begin
            fire_d[idx_q] = 1'b1;
            if (ch_q[idx_q].ctrl.periodic == MODE_ONESHOT) begin
               ch_d[idx_q].ctrl.active = 1'b0;
            end else begin
               ch_d[idx_q].count = ch_q[idx_q].period;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         fire_q  <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            ch_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         fire_q  <= fire_d;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            ch_q[i] <= ch_d[i];
         end
      end
   end

   assign ch_fire = fire_q;

   always_comb begin
      ch_busy = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         ch_busy[i] = ch_q[i].ctrl.active;
      end
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler
// Self-checking bench for tick_scheduler (DIV_VAL=9, NUM_CH=4, CNT_W=8).
// A time-based reference model predicts tick, cfg_ready, ch_fire and ch_busy
// every cycle; table vectors and hand sequences add scenario-level checks.

module tb_tick_scheduler;

   localparam int DIV_VAL = 9;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 8;
   localparam int PER     = DIV_VAL + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [1:0]       cfg_ch = '0;
   logic             cfg_start = 1'b0;
   logic             cfg_periodic = 1'b0;
   logic [CNT_W-1:0] cfg_period = '0;
   logic             tick;
   logic [3:0]       ch_fire;
   logic [3:0]       ch_busy;

   tick_scheduler #(
      .DIV_VAL(DIV_VAL),
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_start   (cfg_start),
      .cfg_periodic(cfg_periodic),
      .cfg_period  (cfg_period),
      .tick        (tick),
      .ch_fire     (ch_fire),
      .ch_busy     (ch_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: t = rising edges since reset release.
   int         t;
   bit         m_active   [NUM_CH];
   bit         m_periodic [NUM_CH];
   int         m_period   [NUM_CH];
   int         m_count    [NUM_CH];
   logic [3:0] m_fire;

   // Observation
   int cnt_fire [NUM_CH];
   int first_t  [NUM_CH];
   int first_tick;
   bit last_acc;
   int acc_t;

   typedef struct {
      int ch;
      bit periodic;
      int period;
      int window;    // ticks observed, counted from the first tick after accept
      int exp_n;     // expected fires in the window
      int exp_off;   // cycles from first tick to first fire
      bit exp_busy;  // ch_busy at end of window
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
      end
   endtask

   function automatic bit m_tick(input int tt);
      return (tt > 0) && ((tt % PER) == 0);
   endfunction

   function automatic bit m_ready(input int tt);
      return !((tt >= PER) && ((tt % PER) < NUM_CH));
   endfunction

   task automatic model_reset();
      t = 0;
      m_fire = '0;
      first_tick = -1;
      for (int i = 0; i < NUM_CH; i++) begin
         m_active[i] = 1'b0;
         m_periodic[i] = 1'b0;
         m_period[i] = 0;
         m_count[i] = 0;
      end
   endtask

   task automatic clear_watch();
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_fire[i] = 0;
         first_t[i] = -1;
      end
   endtask

   // One clock cycle: check outputs mid-cycle, advance the model, move to
   // just after the next rising edge.
   task automatic step();
      logic [3:0] busy_exp;
      int k;
      @(negedge clk);
      chk("tick", 32'(tick), 32'(m_tick(t)));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(t)));
      chk("ch_fire", 32'(ch_fire), 32'(m_fire));
      for (int i = 0; i < NUM_CH; i++) busy_exp[i] = m_active[i];
      chk("ch_busy", 32'(ch_busy), 32'(busy_exp));
      if (tick === 1'b1 && first_tick < 0) first_tick = t;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_fire[i] === 1'b1) begin
            if (cnt_fire[i] == 0) first_t[i] = t;
            cnt_fire[i]++;
         end
      end
      last_acc = cfg_valid && (cfg_ready === 1'b1);
      if (last_acc) acc_t = t;

      m_fire = '0;
      if (cfg_valid && m_ready(t)) begin
         k = int'(cfg_ch);
         if (cfg_start && cfg_period != 0) begin
            m_active[k] = 1'b1;
            m_periodic[k] = cfg_periodic;
            m_period[k] = int'(cfg_period);
            m_count[k] = int'(cfg_period);
         end else begin
            m_active[k] = 1'b0;
         end
      end
      if (t >= PER && (t % PER) < NUM_CH) begin
         k = t % PER;
         if (m_active[k]) begin
            if (m_count[k] > 1) begin
               m_count[k]--;
            end else begin
               m_fire[k] = 1'b1;
               if (m_periodic[k]) m_count[k] = m_period[k];
               else m_active[k] = 1'b0;
            end
         end
      end
      t++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 2 * PER + 2; i++) begin
         if (t >= PER && (t % PER) == p) break;
         step();
      end
   endtask

   task automatic do_cfg(input int ch, input bit start, input bit per, input int period);
      bit acc;
      cfg_ch = 2'(ch);
      cfg_start = start;
      cfg_periodic = per;
      cfg_period = CNT_W'(period);
      cfg_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 12 && !acc; i++) begin
         step();
         acc = last_acc;
      end
      cfg_valid = 1'b0;
      chk("cfg_accept", 32'(acc), 32'd1);
   endtask

   task automatic do_reset_release();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      clear_watch();
   endtask

   initial begin
      int t_tick1;
      int end_t;
      int total;

      vecs[0] = '{ch: 1, periodic: 1'b1, period: 3, window: 9, exp_n: 3, exp_off: 22, exp_busy: 1'b1};
      vecs[1] = '{ch: 0, periodic: 1'b0, period: 1, window: 3, exp_n: 1, exp_off: 1,  exp_busy: 1'b0};
      vecs[2] = '{ch: 2, periodic: 1'b0, period: 2, window: 4, exp_n: 1, exp_off: 13, exp_busy: 1'b0};
      vecs[3] = '{ch: 3, periodic: 1'b1, period: 1, window: 4, exp_n: 4, exp_off: 4,  exp_busy: 1'b1};
      vecs[4] = '{ch: 2, periodic: 1'b1, period: 4, window: 9, exp_n: 2, exp_off: 33, exp_busy: 1'b1};
      vecs[5] = '{ch: 0, periodic: 1'b1, period: 0, window: 3, exp_n: 0, exp_off: 0,  exp_busy: 1'b0};

      model_reset();
      clear_watch();

      // Reset values while held in reset
      #2;
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_fire", 32'(ch_fire), 32'd0);
      chk("rst_busy", 32'(ch_busy), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);

      // Idle run: first tick 10 edges after release, then every 10
      do_reset_release();
      run(45);
      chk("first_tick", 32'(first_tick), 32'(PER));

      // Table vectors
      for (int v = 0; v < 6; v++) begin
         clear_watch();
         wait_phase(5);
         cfg_ch = 2'(vecs[v].ch);
         cfg_start = 1'b1;
         cfg_periodic = vecs[v].periodic;
         cfg_period = CNT_W'(vecs[v].period);
         cfg_valid = 1'b1;
         step();
         cfg_valid = 1'b0;
         t_tick1 = t + (PER - 6);
         end_t = t_tick1 + (vecs[v].window - 1) * PER + 5;
         while (t < end_t) step();
         chk($sformatf("vec%0d_nfires", v), 32'(cnt_fire[vecs[v].ch]), 32'(vecs[v].exp_n));
         if (vecs[v].exp_n > 0)
            chk($sformatf("vec%0d_first_off", v), 32'(first_t[vecs[v].ch] - t_tick1),
                32'(vecs[v].exp_off));
         chk($sformatf("vec%0d_busy", v), 32'(ch_busy[vecs[v].ch]), 32'(vecs[v].exp_busy));
         do_cfg(vecs[v].ch, 1'b0, 1'b0, 0);
      end

      // Request raised at T+1 stays pending until T+4
      clear_watch();
      wait_phase(1);
      do_cfg(2, 1'b1, 1'b0, 2);
      chk("pend_accept_phase", 32'(acc_t % PER), 32'(NUM_CH));
      run(25);
      chk("pend_nfires", 32'(cnt_fire[2]), 32'd1);
      chk("pend_fire_time", 32'(first_t[2] - acc_t), 32'(6 + PER + 3));

      // Stop, then start with period 0: channel 3 never fires
      clear_watch();
      wait_phase(5);
      do_cfg(3, 1'b1, 1'b1, 5);
      run(2 * PER);
      do_cfg(3, 1'b0, 1'b0, 0);
      run(2);
      chk("ch3_busy_after_stop", 32'(ch_busy[3]), 32'd0);
      do_cfg(3, 1'b1, 1'b0, 0);
      run(60);
      chk("ch3_nfires", 32'(cnt_fire[3]), 32'd0);
      chk("ch3_busy_final", 32'(ch_busy[3]), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch = 2'($urandom_range(0, 3));
         cfg_start = ($urandom_range(0, 4) != 0);
         cfg_periodic = 1'($urandom_range(0, 1));
         cfg_period = CNT_W'($urandom_range(0, 4));
         step();
      end
      cfg_valid = 1'b0;
      for (int i = 0; i < NUM_CH; i++) do_cfg(i, 1'b0, 1'b0, 0);

      // Asynchronous reset in the middle of a sweep
      do_cfg(0, 1'b1, 1'b1, 1);
      do_cfg(1, 1'b1, 1'b1, 1);
      wait_phase(2);
      chk("pre_reset_fire1", 32'(ch_fire[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_tick", 32'(tick), 32'd0);
      chk("async_rst_fire", 32'(ch_fire), 32'd0);
      chk("async_rst_busy", 32'(ch_busy), 32'd0);
      chk("async_rst_ready", 32'(cfg_ready), 32'd1);
      do_reset_release();
      run(35);
      chk("post_rst_first_tick", 32'(first_tick), 32'(PER));
      total = 0;
      for (int i = 0; i < NUM_CH; i++) total += cnt_fire[i];
      chk("post_rst_no_fires", 32'(total), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
